// File: rtl/serial_parity_pkg.sv
// Shared definitions for the serial parity receiver and its matching generator:
// FSM state encoding, parity sense constants and the default frame width.
package serial_parity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam int PARITY_EVEN       = 0;
  localparam int PARITY_ODD        = 1;
  localparam int DEFAULT_DATA_BITS = 8;

  // acc holds the XOR of data and parity bits; it must equal the parity sense.
  function automatic logic parity_mismatch(input logic acc, input int odd);
    return acc != odd[0];
  endfunction

endpackage

// File: rtl/serial_parity_rx_if.sv
// Bundle between the bit-strobe source (master) and the serial parity receiver (slave).
// err_count exists only when SERIAL_PARITY_RX_ERRCNT_EN is defined.
interface serial_parity_rx_if #(
  parameter int DATA_BITS = serial_parity_pkg::DEFAULT_DATA_BITS
);

  logic                 din;
  logic                 din_valid;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
  logic [7:0]           err_count;
`endif

  modport master (
    output din, din_valid,
    input  data, data_valid, parity_err, frame_err, busy
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  din, din_valid,
    output data, data_valid, parity_err, frame_err, busy
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    , output err_count
`endif
  );

endinterface

// File: rtl/xor_acc.sv
// One-bit XOR accumulator with synchronous clear (priority) and enable.
// Shared by the parity receiver and the parity generator.
module xor_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic d_i,
  output logic acc_o
);

  logic acc_q;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= 1'b0;
    end else if (clr_i) begin
      acc_q <= 1'b0;
    end else if (en_i) begin
      acc_q <= acc_q ^ d_i;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/serial_parity_rx.sv
// Start/data/parity/stop frame receiver with XOR parity check, stalled by din_valid.
// Define SERIAL_PARITY_RX_ERRCNT_EN to add the saturating 8-bit err_count output.
module serial_parity_rx
  import serial_parity_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int ODD       = PARITY_EVEN
) (
  input  logic               clk,
  input  logic               rst,
  serial_parity_rx_if.slave  rx_if
);

  localparam int                CNT_W    = $clog2(DATA_BITS) + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
  logic                 acc_clr, acc_en, acc;

  xor_acc u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .d_i   (rx_if.din),
    .acc_o (acc)
  );

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;

    if (rx_if.din_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_if.din) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            acc_clr   = 1'b1;
          end
        end
        ST_DATA: begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (bit_cnt_q == CNT_W'(i)) shreg_d[i] = rx_if.din;
          end
          acc_en    = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          acc_en  = 1'b1;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d      = ST_IDLE;
          data_d       = shreg_q;
          parity_err_d = parity_mismatch(acc, ODD);
          frame_err_d  = ~rx_if.din;
          data_valid_d = 1'b1;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      // NOTE: the shift register is reset too, so a dropped partial frame never leaks into data.
      shreg_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_if.data       = data_q;
  assign rx_if.data_valid = data_valid_q;
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.busy       = busy_q;

`ifdef SERIAL_PARITY_RX_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // A frame with both errors counts once; the count saturates.
  always_comb begin
    err_count_d = err_count_q;
    if (data_valid_d && (parity_err_d || frame_err_d) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count_q <= 8'd0;
    else     err_count_q <= err_count_d;
  end

  assign rx_if.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: an even and an odd receiver share one serial line and
// are compared every cycle against a frame-level model, plus directed literal checks.
module tb_serial_parity_rx;

  localparam int DB = 8;

  logic clk;
  logic rst;
  logic din;
  logic din_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cycles;

  serial_parity_rx_if #(.DATA_BITS(DB)) bus_e ();
  serial_parity_rx_if #(.DATA_BITS(DB)) bus_o ();

  assign bus_e.din       = din;
  assign bus_e.din_valid = din_valid;
  assign bus_o.din       = din;
  assign bus_o.din_valid = din_valid;

  serial_parity_rx #(.DATA_BITS(DB), .ODD(0)) u_even (
    .clk   (clk),
    .rst   (rst),
    .rx_if (bus_e.slave)
  );

  serial_parity_rx #(.DATA_BITS(DB), .ODD(1)) u_odd (
    .clk   (clk),
    .rst   (rst),
    .rx_if (bus_o.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: after a start bit, collect DATA_BITS+1 bits, then the stop bit
  // closes the frame and the outcome follows from the count of ones.
  function automatic bit par_bad(input logic [DB:0] bits, input int odd);
    return ($countones(bits) & 1) != odd;
  endfunction

  logic          m_busy, m_valid, m_seen, m_perr_e, m_perr_o, m_ferr;
  logic [DB-1:0] m_data;
  logic [DB:0]   m_bits;
  int            m_n, m_cnt_e, m_cnt_o;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_seen <= 1'b0;
      m_perr_e <= 1'b0; m_perr_o <= 1'b0; m_ferr <= 1'b0;
      m_data <= '0; m_bits <= '0; m_n <= 0; m_cnt_e <= 0; m_cnt_o <= 0;
    end else begin
      m_valid <= 1'b0;
      if (din_valid) begin
        if (!m_busy) begin
          if (!din) begin
            m_busy <= 1'b1;
            m_n    <= 0;
          end
        end else if (m_n < DB + 1) begin
          m_bits <= {din, m_bits[DB:1]};
          m_n    <= m_n + 1;
        end else begin
          m_busy   <= 1'b0;
          m_valid  <= 1'b1;
          m_seen   <= 1'b1;
          m_data   <= m_bits[DB-1:0];
          m_perr_e <= par_bad(m_bits, 0);
          m_perr_o <= par_bad(m_bits, 1);
          m_ferr   <= !din;
          if ((par_bad(m_bits, 0) || !din) && m_cnt_e < 255) m_cnt_e <= m_cnt_e + 1;
          if ((par_bad(m_bits, 1) || !din) && m_cnt_o < 255) m_cnt_o <= m_cnt_o + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("valid_e", 32'(bus_e.data_valid), 32'(m_valid));
      check("valid_o", 32'(bus_o.data_valid), 32'(m_valid));
      check("busy_e",  32'(bus_e.busy),       32'(m_busy));
      check("busy_o",  32'(bus_o.busy),       32'(m_busy));
      if (m_seen) begin
        check("data_e", 32'(bus_e.data),       32'(m_data));
        check("data_o", 32'(bus_o.data),       32'(m_data));
        check("perr_e", 32'(bus_e.parity_err), 32'(m_perr_e));
        check("perr_o", 32'(bus_o.parity_err), 32'(m_perr_o));
        check("ferr_e", 32'(bus_e.frame_err),  32'(m_ferr));
        check("ferr_o", 32'(bus_o.frame_err),  32'(m_ferr));
      end
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
      check("errcnt_e", 32'(bus_e.err_count), 32'(m_cnt_e));
      check("errcnt_o", 32'(bus_o.err_count), 32'(m_cnt_o));
`endif
    end
  end

  task automatic step(input logic d, input logic v);
    @(negedge clk);
    if (bus_e.busy) busy_cycles++;
    din       = d;
    din_valid = v;
  endtask

  task automatic stall2(input logic d);
    step(d, 1'b0);
    step(d, 1'b0);
  endtask

  // Stall cycles drive the inverted bit so a stall that advanced the FSM corrupts the word.
  task automatic send_frame(input logic [DB-1:0] w, input logic p, input logic stop, input bit stall);
    step(1'b0, 1'b1);
    if (stall) stall2(1'b1);
    for (int i = 0; i < DB; i++) begin
      step(w[i], 1'b1);
      if (stall) stall2(~w[i]);
    end
    step(p, 1'b1);
    if (stall) stall2(~p);
    step(stop, 1'b1);
  endtask

  // One idle bit; on return we sit at the negedge where data_valid must be high.
  task automatic finish_frame();
    step(1'b1, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; din = 1'b1; din_valid = 1'b0; busy_cycles = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 32'(bus_e.data_valid), 32'd0);
    check("rst_data",  32'(bus_e.data),       32'd0);
    check("rst_busy",  32'(bus_e.busy),       32'd0);
    check("rst_perr",  32'(bus_e.parity_err), 32'd0);
    check("rst_ferr",  32'(bus_e.frame_err),  32'd0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Even parity, clean frame 0xA5
    busy_cycles = 0;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    finish_frame();
    check("a5_valid",  32'(bus_e.data_valid), 32'd1);
    check("a5_data",   32'(bus_e.data),       32'hA5);
    check("a5_perr_e", 32'(bus_e.parity_err), 32'd0);
    check("a5_perr_o", 32'(bus_o.parity_err), 32'd1);
    check("a5_ferr",   32'(bus_e.frame_err),  32'd0);
    check("a5_busy_n", 32'(busy_cycles),      32'd10);
    step(1'b1, 1'b1);

    // Same word with a wrong parity bit
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    finish_frame();
    check("a5p_data",  32'(bus_e.data),       32'hA5);
    check("a5p_perr",  32'(bus_e.parity_err), 32'd1);
    check("a5p_ferr",  32'(bus_e.frame_err),  32'd0);

    // 0x00 with parity 1, then 0
    send_frame(8'h00, 1'b1, 1'b1, 1'b0);
    finish_frame();
    check("z1_perr_o", 32'(bus_o.parity_err), 32'd0);
    check("z1_perr_e", 32'(bus_e.parity_err), 32'd1);
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    finish_frame();
    check("z0_perr_o", 32'(bus_o.parity_err), 32'd1);
    check("z0_perr_e", 32'(bus_e.parity_err), 32'd0);

    // Stalled strobe, stop bit 0
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    finish_frame();
    check("3c_valid", 32'(bus_e.data_valid), 32'd1);
    check("3c_data",  32'(bus_e.data),       32'h3C);
    check("3c_ferr",  32'(bus_e.frame_err),  32'd1);
    check("3c_perr",  32'(bus_e.parity_err), 32'd0);

    // Both errors in one frame
    send_frame(8'h01, 1'b0, 1'b0, 1'b0);
    finish_frame();
    check("both_perr", 32'(bus_e.parity_err), 32'd1);
    check("both_ferr", 32'(bus_e.frame_err),  32'd1);

    // Reset after four data bits, then a clean 0x5A
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1; din = 1'b1; din_valid = 1'b1;
    #1;
    check("mid_rst_busy",  32'(bus_e.busy),       32'd0);
    check("mid_rst_data",  32'(bus_e.data),       32'd0);
    check("mid_rst_ferr",  32'(bus_e.frame_err),  32'd0);
    check("mid_rst_valid", 32'(bus_e.data_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    finish_frame();
    check("5a_valid", 32'(bus_e.data_valid), 32'd1);
    check("5a_data",  32'(bus_e.data),       32'h5A);
    check("5a_perr",  32'(bus_e.parity_err), 32'd0);
    check("5a_ferr",  32'(bus_e.frame_err),  32'd0);

    // Back-to-back frames with no idle gap
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    finish_frame();
    check("b2b_data", 32'(bus_e.data),       32'hFF);
    check("b2b_perr", 32'(bus_e.parity_err), 32'd0);

`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    for (int f = 0; f < 260; f++) begin
      send_frame(8'h01, 1'b0, 1'b1, 1'b0);
      finish_frame();
    end
    check("errcnt_sat", 32'(bus_e.err_count), 32'd255);
`endif

    repeat (4) step(1'b1, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
